// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: fetches a word from instruction memory,
// hands it to the core, waits for completion, then advances or branches the PC.
module fetch_sequencer #(
   parameter int PC_W        = 8,   // must not exceed 12: branch target is instruction[PC_W+3:4]
   parameter int ACK_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [PC_W-1:0] mem_addr,
   output logic            mem_req,
   input  logic            mem_ack,
   input  logic [15:0]     mem_rdata,
   output logic [15:0]     instruction,
   output logic            inst_valid,
   input  logic            core_done,
   input  logic            cmp_eq,
   input  logic            cmp_gt,
   input  logic            cmp_lt,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     retired,
   output logic            halted,
   output logic            error,
   output logic [2:0]      state_dbg
);

   // Handshakes: mem_req is held high for the whole FETCH state and the
   // request completes in the first cycle mem_ack is sampled high; inst_valid
   // is a single-cycle pulse with no back-pressure, and core_done is only
   // honoured while the sequencer waits in EXEC.

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_EXEC   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_HALT   = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [15:0] HALT_WORD = 16'hFFFF;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             is_branch;
   logic             cond_true;
   logic [PC_W-1:0]  target;
   logic [PC_W-1:0]  pc_next;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         // An ack in the final allowed cycle still completes the fetch.
         ST_FETCH: begin
            if (mem_ack)                    state_d = ST_ISSUE;
            else if (wait_cnt == CNT_LAST)  state_d = ST_ERROR;
         end
         ST_ISSUE:  state_d = (instruction == HALT_WORD) ? ST_HALT : ST_EXEC;
         ST_EXEC:   if (core_done) state_d = ST_UPDATE;
         ST_UPDATE: state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      is_branch = (instruction[1:0] == 2'b10);
      target    = instruction[PC_W+3:4];
      cond_true = 1'b0;
      case (instruction[3:2])
         2'b00:   cond_true = cmp_eq;
         2'b01:   cond_true = cmp_gt;
         2'b10:   cond_true = cmp_lt;
         default: cond_true = 1'b1;
      endcase
      pc_next = (is_branch && cond_true) ? target : pc + PC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pc          <= '0;
         instruction <= '0;
         retired     <= '0;
         wait_cnt    <= '0;
      end else begin
         state_q  <= state_d;
         // The wait counter only runs in FETCH, so it is clear on every entry.
         wait_cnt <= '0;
         case (state_q)
            ST_IDLE: if (start) pc <= '0;
            ST_FETCH: begin
               if (mem_ack) instruction <= mem_rdata;
               else         wait_cnt    <= wait_cnt + CNT_W'(1);
            end
            ST_UPDATE: begin
               pc <= pc_next;
               if (retired != 16'hFFFF) retired <= retired + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign mem_addr   = pc;
   assign mem_req    = (state_q == ST_FETCH);
   assign inst_valid = (state_q == ST_ISSUE) && (instruction != HALT_WORD);
   assign halted     = (state_q == ST_HALT);
   assign error      = (state_q == ST_ERROR);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized programs run
// against a program-level model of PC/retire behaviour.
module tb_fetch_sequencer;

   localparam int PC_W        = 8;
   localparam int ACK_TIMEOUT = 16;
   localparam int MEM_N       = 1 << PC_W;

   logic            clk = 1'b0;
   logic            reset, start, mem_ack, core_done;
   logic            cmp_eq, cmp_gt, cmp_lt;
   logic [15:0]     mem_rdata;
   logic [PC_W-1:0] mem_addr, pc;
   logic            mem_req, inst_valid, halted, error;
   logic [15:0]     instruction, retired;
   logic [2:0]      state_dbg;

   logic [15:0] mem [MEM_N];
   logic [15:0] exp_q [$];
   int          ack_delay, done_delay;
   bit          spur_en, noise_en;
   int          req_age, exec_age;
   bit          busy;
   int          n_checks, n_bad;

   fetch_sequencer #(.PC_W(PC_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instruction(instruction), .inst_valid(inst_valid), .core_done(core_done),
      .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
      .pc(pc), .retired(retired), .halted(halted), .error(error), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- memory and core responders ----------------
   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = mem_req && (req_age >= ack_delay);
   assign core_done = (busy && exec_age >= done_delay) || (spur_en && mem_req);

   always_ff @(posedge clk) begin
      if (mem_req) req_age <= req_age + 1;
      else         req_age <= 0;
      if (reset)                   busy <= 1'b0;
      else if (inst_valid) begin
         busy     <= 1'b1;
         exec_age <= 0;
      end
      else if (busy && core_done)  busy <= 1'b0;
      else if (busy)               exec_age <= exec_age + 1;
   end

   // ---------------- driver tasks ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (noise_en) start = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_cond(input int which, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         case (which)
            0:       ok = mem_req;
            1:       ok = inst_valid;
            2:       ok = inst_valid || halted;
            default: ok = error;
         endcase
         if (ok) break;
         tick();
      end
      if (!ok) check_eq($sformatf("wait_%0d", which), 0, 1);
   endtask

   task automatic do_reset();
      noise_en = 1'b0;
      start    = 1'b0;
      reset    = 1'b1;
      tick();
      check_eq("rst_pc",      32'(pc),          0);
      check_eq("rst_retired", 32'(retired),     0);
      check_eq("rst_instr",   32'(instruction), 0);
      check_eq("rst_req",     32'(mem_req),     0);
      check_eq("rst_iv",      32'(inst_valid),  0);
      check_eq("rst_halted",  32'(halted),      0);
      check_eq("rst_error",   32'(error),       0);
      reset = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [15:0] rand_plain();
      logic [15:0] w;
      w = 16'($urandom);
      if (w[1:0] == 2'b10) w[0] = 1'b1;
      if (w == 16'hFFFF)   w = 16'h7FFF;
      return w;
   endfunction

   // Program-level rule: branches (low bits 10) jump to bits [11:4] when the
   // selected flag holds; everything else steps to the next address mod 256.
   function automatic int next_pc(input int cur, input logic [15:0] w);
      bit take;
      take = 1'b0;
      if (w[1:0] == 2'b10) begin
         case (w[3:2])
            2'd0:    take = cmp_eq;
            2'd1:    take = cmp_gt;
            2'd2:    take = cmp_lt;
            default: take = 1'b1;
         endcase
      end
      return take ? int'(w[PC_W+3:4]) : (cur + 1) % MEM_N;
   endfunction

   // ---------------- directed scenarios ----------------
   task automatic test_linear();
      int pulses [$];
      for (int a = 0; a < 3; a++) mem[a] = rand_plain();
      mem[3] = 16'hFFFF;
      ack_delay = 0; done_delay = 0; spur_en = 1'b0;
      do_reset();
      start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         start = 1'b0;
         if (inst_valid) pulses.push_back(c);
      end
      check_eq("lin_npulse", pulses.size(), 3);
      if (pulses.size() == 3) begin
         check_eq("lin_p0", pulses[0], 2);
         check_eq("lin_p1", pulses[1], 6);
         check_eq("lin_p2", pulses[2], 10);
      end
      check_eq("lin_halted",  32'(halted),  1);
      check_eq("lin_retired", 32'(retired), 3);
      check_eq("lin_pc",      32'(pc),      3);
      start = 1'b1;
      repeat (4) tick();
      start = 1'b0;
      check_eq("halt_sticky", 32'(halted),  1);
      check_eq("halt_ret",    32'(retired), 3);
      check_eq("halt_req",    32'(mem_req), 0);
   endtask

   task automatic test_branch(input bit eq);
      bit ok;
      mem[0] = 16'h0052; mem[1] = rand_plain(); mem[5] = rand_plain();
      cmp_eq = eq; cmp_gt = 1'($urandom); cmp_lt = 1'($urandom);
      ack_delay = 0; done_delay = 1;
      do_reset();
      start_run();
      wait_cond(1, 20, ok);
      tick();
      wait_cond(0, 20, ok);
      check_eq(eq ? "br_taken" : "br_not_taken", 32'(mem_addr), eq ? 5 : 1);
   endtask

   task automatic test_wrap();
      bit ok;
      mem[0] = 16'h0FFE; mem[255] = rand_plain();
      ack_delay = 1; done_delay = 0;
      do_reset();
      start_run();
      wait_cond(1, 20, ok); tick();
      wait_cond(0, 20, ok);
      check_eq("wrap_target", 32'(mem_addr), 255);
      wait_cond(1, 20, ok); tick();
      wait_cond(0, 20, ok);
      check_eq("wrap_zero", 32'(mem_addr), 0);
      check_eq("wrap_ret",  32'(retired),  2);
   endtask

   task automatic test_timeout();
      int n;
      mem[0] = rand_plain();
      ack_delay = 1000; done_delay = 0;
      do_reset();
      start_run();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req) n++;
         if (error) break;
         tick();
      end
      check_eq("to_cycles", n, ACK_TIMEOUT);
      check_eq("to_error",  32'(error),   1);
      check_eq("to_req",    32'(mem_req), 0);
      start = 1'b1; tick(); tick(); start = 1'b0;
      check_eq("err_sticky", 32'(error), 1);
      ack_delay = ACK_TIMEOUT - 1;
      do_reset();
      start_run();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req) n++;
         if (inst_valid || error) break;
         tick();
      end
      check_eq("late_cycles", n, ACK_TIMEOUT);
      check_eq("late_iv",     32'(inst_valid), 1);
      check_eq("late_error",  32'(error),      0);
   endtask

   task automatic test_reset_exec();
      bit ok;
      mem[0] = rand_plain(); mem[1] = rand_plain();
      ack_delay = 0; done_delay = 0;
      do_reset();
      start_run();
      wait_cond(1, 20, ok); tick();
      wait_cond(1, 20, ok);
      done_delay = 1000;
      repeat (3) tick();
      check_eq("exec_ret", 32'(retired), 1);
      do_reset();
      tick(); tick();
      check_eq("idle_req", 32'(mem_req), 0);
      check_eq("idle_pc",  32'(pc),      0);
      done_delay = 0;
      start_run();
      check_eq("restart_req",  32'(mem_req),  1);
      check_eq("restart_addr", 32'(mem_addr), 0);
   endtask

   // ---------------- randomized programs ----------------
   task automatic run_random(input int n_instr);
      int m_pc, m_ret, r;
      bit ok, stop;
      logic [15:0] got_w;
      for (int a = 0; a < MEM_N; a++) begin
         r = $urandom_range(0, 99);
         if (r < 8)       mem[a] = 16'hFFFF;
         else if (r < 45) mem[a] = {4'($urandom), 8'($urandom), 2'($urandom), 2'b10};
         else             mem[a] = rand_plain();
      end
      spur_en = 1'($urandom_range(0, 1));
      ack_delay = 0; done_delay = 0;
      do_reset();
      m_pc = 0; m_ret = 0; stop = 1'b0;
      start_run();
      noise_en = 1'b1;
      for (int i = 0; i < n_instr && !stop; i++) begin
         ack_delay  = ($urandom_range(0, 19) == 0) ? ACK_TIMEOUT + 4
                                                   : int'($urandom_range(0, ACK_TIMEOUT - 1));
         done_delay = $urandom_range(0, 4);
         wait_cond(0, 60, ok);
         if (!ok) break;
         check_eq("fetch_addr", 32'(mem_addr), m_pc);
         check_eq("pc",         32'(pc),       m_pc);
         check_eq("retired",    32'(retired),  m_ret);
         if (ack_delay >= ACK_TIMEOUT) begin
            wait_cond(3, 40, ok);
            check_eq("err_req", 32'(mem_req), 0);
            check_eq("err_pc",  32'(pc),      m_pc);
            stop = 1'b1;
         end else begin
            exp_q.push_back(mem[m_pc]);
            wait_cond(2, 40, ok);
            if (!ok) break;
            got_w = exp_q.pop_front();
            if (got_w == 16'hFFFF) begin
               check_eq("halt",     32'(halted),     1);
               check_eq("halt_iv",  32'(inst_valid), 0);
               check_eq("halt_cnt", 32'(retired),    m_ret);
               stop = 1'b1;
            end else begin
               check_eq("iv",    32'(inst_valid),  1);
               check_eq("instr", 32'(instruction), 32'(got_w));
               {cmp_eq, cmp_gt, cmp_lt} = 3'($urandom);
               m_pc = next_pc(m_pc, got_w);
               if (m_ret < 65535) m_ret++;
               tick();
               check_eq("iv_pulse", 32'(inst_valid), 0);
            end
         end
      end
      exp_q.delete();
      if (stop) begin
         repeat (3) tick();
         check_eq("stuck",      32'(halted || error), 1);
         check_eq("stuck_ret",  32'(retired),         m_ret);
      end
      do_reset();
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      reset = 1'b1; start = 1'b0;
      cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0;
      ack_delay = 0; done_delay = 0; spur_en = 1'b0; noise_en = 1'b0;
      n_checks = 0; n_bad = 0;
      do_reset();
      test_linear();
      test_branch(1'b1);
      test_branch(1'b0);
      test_wrap();
      test_timeout();
      test_reset_exec();
      for (int k = 0; k < 25; k++) run_random(40);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
